tx_frame_sched: RTL

Round-robin frame scheduler that builds the 32-bit + 4-bit K-flag word stream driven into the link CRC inserter (tx_crc).
Shares one transmit link among N_REQ word sources. Emits idle commas, data frames, end marker and CRC slot, plus padding words.
The word sequence is exactly the one tx_crc needs: CRC reset on the 3rd consecutive comma, CRC substituted on the first k=0 word after a single comma following data.
Sits directly upstream of tx_crc in the CPPF transmit path.

---
 rtl/tx_frame_sched.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/tx_frame_sched.sv
// ============================================================================
// Module   : tx_frame_sched
// Purpose  : Round-robin frame scheduler for the tx_crc link word stream.
//            Several word sources share one transmit link. Between frames the
//            link carries idle commas. A granted frame is FRAME_LEN data words
//            (k=0), then one marker comma, then a zero CRC slot (k=0). tx_crc
//            overwrites that slot with the running CRC.
// Option   : `define TX_SCHED_PAD_INSERT_EN to force one pad word
//            (PAD_WORD, k=4'hF) every PAD_PERIOD output cycles in any state.
// Ports    : clk        - link word clock
//            rst        - synchronous active-high reset
//            req        - per-source frame request (level)
//            src_data   - packed source words, source i at [32*i+31:32*i]
//            src_valid  - per-source word available
//            src_ack    - combinational one-hot, granted word consumed
//            gnt        - registered one-hot grant, held DATA..CRC
//            dout/kout  - registered word and K flags to tx_crc
//            busy       - high while a frame is in DATA, MARK or CRC
//            frame_done - one-cycle pulse while the CRC slot is on dout
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tx_frame_sched #(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned FRAME_LEN  = 8,
  parameter int unsigned MIN_GAP    = 3,
  parameter logic [31:0] COMMA_WORD = 32'h0000_00BC,
  parameter logic [31:0] PAD_WORD   = 32'h0000_F7F7,
  parameter int unsigned PAD_PERIOD = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ*32-1:0]   src_data,
  input  logic [N_REQ-1:0]      src_valid,
  output logic [N_REQ-1:0]      src_ack,
  output logic [N_REQ-1:0]      gnt,
  output logic [31:0]           dout,
  output logic [3:0]            kout,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int unsigned c_idx_w  = $clog2(N_REQ);
  localparam int unsigned c_word_w = $clog2(FRAME_LEN + 1);
  localparam int unsigned c_gap_w  = $clog2(MIN_GAP + 1);

  localparam logic [c_idx_w:0]    c_nreq      = (c_idx_w + 1)'(N_REQ);
  localparam logic [c_word_w-1:0] c_word_last = c_word_w'(FRAME_LEN - 1);
  localparam logic [c_gap_w-1:0]  c_gap_max   = c_gap_w'(MIN_GAP);
  // The comma emitted in the decision cycle itself counts toward the gap,
  // so the frame may be granted once MIN_GAP-1 commas are already out.
  localparam logic [c_gap_w-1:0]  c_gap_arm   = c_gap_w'(MIN_GAP - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_MARK = 2'd2,
    ST_CRC  = 2'd3
  } state_t;

  state_t              r_state;
  logic [N_REQ-1:0]    r_gnt;
  logic [c_idx_w-1:0]  r_rr;
  logic [c_word_w-1:0] r_word_cnt;
  logic [c_gap_w-1:0]  r_gap_cnt;
  logic [31:0]         r_dout;
  logic [3:0]          r_kout;
  logic                r_busy;
  logic                r_frame_done;

  logic                w_pad_force;
  logic [c_idx_w:0]    w_cand;
  logic [c_idx_w-1:0]  w_win_idx;
  logic                w_win_found;
  logic [c_idx_w:0]    w_rr_inc;
  logic [c_idx_w-1:0]  w_rr_next;
  logic [N_REQ-1:0]    w_win_onehot;
  logic [31:0]         w_src_word;
  logic                w_src_valid;
  logic                w_gap_ok;

`ifdef TX_SCHED_PAD_INSERT_EN
  localparam int unsigned          c_pad_w    = $clog2(PAD_PERIOD);
  localparam logic [c_pad_w-1:0]   c_pad_last = c_pad_w'(PAD_PERIOD - 1);

  logic [c_pad_w-1:0] r_pad_cnt;

  // Free-running over every output cycle; the last count is the pad slot.
  assign w_pad_force = (r_pad_cnt == c_pad_last);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pad_cnt <= '0;
    end else if (w_pad_force) begin
      r_pad_cnt <= '0;
    end else begin
      r_pad_cnt <= r_pad_cnt + c_pad_w'(1);
    end
  end
`else
  // PAD_PERIOD is always >= 4, so this folds to a constant 0.
  assign w_pad_force = (PAD_PERIOD == 0);
`endif

  // First requester at or after the round-robin pointer, wrapping.
  always_comb begin
    w_win_idx   = '0;
    w_win_found = 1'b0;
    w_cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_cand = {1'b0, r_rr} + (c_idx_w + 1)'(k);
      if (w_cand >= c_nreq) begin
        w_cand = w_cand - c_nreq;
      end
      if (!w_win_found && req[w_cand[c_idx_w-1:0]]) begin
        w_win_found = 1'b1;
        w_win_idx   = w_cand[c_idx_w-1:0];
      end
    end
  end

  assign w_rr_inc     = {1'b0, w_win_idx} + (c_idx_w + 1)'(1);
  assign w_rr_next    = (w_rr_inc == c_nreq) ? '0 : w_rr_inc[c_idx_w-1:0];
  assign w_win_onehot = {{(N_REQ - 1){1'b0}}, 1'b1} << w_win_idx;
  assign w_gap_ok     = (r_gap_cnt >= c_gap_arm);

  // Grant is one-hot, so OR-ing the masked words selects the granted source.
  always_comb begin
    w_src_word = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (r_gnt[k]) begin
        w_src_word = w_src_word | src_data[32*k +: 32];
      end
    end
  end

  assign w_src_valid = |(src_valid & r_gnt);

  // A word is consumed only when it is actually placed on the link.
  assign src_ack = (!rst && (r_state == ST_DATA) && !w_pad_force)
                   ? (src_valid & r_gnt) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_gnt        <= '0;
      r_rr         <= '0;
      r_word_cnt   <= '0;
      r_gap_cnt    <= '0;
      r_dout       <= COMMA_WORD;
      r_kout       <= 4'b0001;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (w_pad_force) begin
        // Forced pad freezes every other piece of state for this cycle.
        r_dout <= PAD_WORD;
        r_kout <= 4'b1111;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_dout <= COMMA_WORD;
            r_kout <= 4'b0001;
            if (r_gap_cnt != c_gap_max) begin
              r_gap_cnt <= r_gap_cnt + c_gap_w'(1);
            end
            if (w_gap_ok && w_win_found) begin
              r_gnt   <= w_win_onehot;
              r_rr    <= w_rr_next;
              r_busy  <= 1'b1;
              r_state <= ST_DATA;
            end
          end
          ST_DATA: begin
            if (w_src_valid) begin
              r_dout     <= w_src_word;
              r_kout     <= 4'b0000;
              r_word_cnt <= r_word_cnt + c_word_w'(1);
              if (r_word_cnt == c_word_last) begin
                r_state <= ST_MARK;
              end
            end else begin
              r_dout <= PAD_WORD;
              r_kout <= 4'b1111;
            end
          end
          ST_MARK: begin
            r_dout  <= COMMA_WORD;
            r_kout  <= 4'b0001;
            r_state <= ST_CRC;
          end
          ST_CRC: begin
            // Zero CRC slot; tx_crc substitutes the CRC here.
            r_dout       <= 32'h0;
            r_kout       <= 4'b0000;
            r_frame_done <= 1'b1;
            r_gnt        <= '0;
            r_busy       <= 1'b0;
            r_word_cnt   <= '0;
            r_gap_cnt    <= '0;
            r_state      <= ST_IDLE;
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign gnt        = r_gnt;
  assign dout       = r_dout;
  assign kout       = r_kout;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;

endmodule

`default_nettype wire
